// File: rtl/be_pkg.sv
// Shared LSU types: operation codes, FSM states and small decode helpers
// used by the LSU top and its lane-steering unit.
package be_pkg;

    typedef enum logic [3:0] {
        LB, LH, LW, LBU, LHU, SB, SH, SW, LD, LWU, SD
    } lsu_op_t;

    typedef enum logic [1:0] {
        IDLE, ACCESS, RESP
    } lsu_state_t;

    // log2 of the access size in bytes
    function automatic logic [1:0] op_size(lsu_op_t op);
        case (op)
            LB, LBU, SB: return 2'd0;
            LH, LHU, SH: return 2'd1;
            LW, LWU, SW: return 2'd2;
            default:     return 2'd3;
        endcase
    endfunction

    function automatic logic op_is_store(lsu_op_t op);
        return op inside {SB, SH, SW, SD};
    endfunction

    function automatic logic op_unsigned(lsu_op_t op);
        return op inside {LBU, LHU, LWU};
    endfunction

    // Natural-alignment check; doubleword ops are rejected outright on a
    // 32-bit datapath since they cannot fit in one bus beat.
    function automatic logic op_misaligned(lsu_op_t op, logic [2:0] off, logic xlen64);
        logic [2:0] am;
        case (op_size(op))
            2'd0:    am = 3'b000;
            2'd1:    am = 3'b001;
            2'd2:    am = 3'b011;
            default: am = 3'b111;
        endcase
        return (|(off & am)) || ((op_size(op) == 2'd3) && !xlen64);
    endfunction

endpackage

// File: rtl/rv32i_lsu_if.sv
// Request/response and memory-bus signal bundle for the LSU.
// slave = the LSU itself, master = the core/bus environment around it.
interface rv32i_lsu_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    import be_pkg::*;

    logic                req_valid;
    logic                req_ready;
    lsu_op_t             req_op;
    logic [ADDR_W-1:0]   req_addr;
    logic [XLEN-1:0]     req_wdata;

    logic                resp_valid;
    logic [XLEN-1:0]     resp_rdata;
    logic                resp_err;

    logic [ADDR_W-1:0]   bus_addr;
    logic [XLEN-1:0]     bus_wrdata;
    logic [XLEN/8-1:0]   bus_be;
    logic                bus_wren;
    logic                bus_rden;
    logic                bus_ack;
    logic [XLEN-1:0]     bus_rddata;

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, bus_ack, bus_rddata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               bus_addr, bus_wrdata, bus_be, bus_wren, bus_rden
    );

    modport master (
        output req_valid, req_op, req_addr, req_wdata, bus_ack, bus_rddata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               bus_addr, bus_wrdata, bus_be, bus_wren, bus_rden
    );

endinterface

// File: rtl/rv32i_lsu_align.sv
// Combinational lane steering: store data replication and byte enables,
// load lane extraction with sign/zero extension.
module rv32i_lsu_align
    import be_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  lsu_op_t                    op,
    input  logic [$clog2(XLEN/8)-1:0]  off,
    input  logic [XLEN-1:0]            wdata,
    input  logic [XLEN-1:0]            rddata,
    output logic [XLEN-1:0]            wrdata,
    output logic [XLEN/8-1:0]          be,
    output logic [XLEN-1:0]            rdata
);
    localparam int BE_W = XLEN / 8;

    logic [7:0]      mask;
    logic [XLEN-1:0] lane;

    // Store side: replicate the item into every lane of its size, shift the mask
    always_comb begin
        case (op_size(op))
            2'd0: begin mask = 8'h01; wrdata = {BE_W{wdata[7:0]}};          end
            2'd1: begin mask = 8'h03; wrdata = {(XLEN/16){wdata[15:0]}};    end
            2'd2: begin mask = 8'h0F; wrdata = {(XLEN/32){wdata[31:0]}};    end
            default: begin mask = 8'hFF; wrdata = wdata;                    end
        endcase
        be = BE_W'(mask) << off;
    end

    // Load side: bring the addressed lane down to bit 0 and extend it
    always_comb begin
        lane = rddata >> {off, 3'b000};
        case (op_size(op))
            2'd0: rdata = op_unsigned(op) ? XLEN'(lane[7:0])  : XLEN'($signed(lane[7:0]));
            2'd1: rdata = op_unsigned(op) ? XLEN'(lane[15:0]) : XLEN'($signed(lane[15:0]));
            2'd2: rdata = op_unsigned(op) ? XLEN'(lane[31:0]) : XLEN'($signed(lane[31:0]));
            default: rdata = lane;
        endcase
    end

endmodule

// File: rtl/rv32i_lsu.sv
// Single-outstanding load/store unit: IDLE -> ACCESS -> RESP.
// Optional build macro RV32I_LSU_TIMEOUT_EN adds an ACCESS watchdog that
// returns an error response after TIMEOUT_CYC cycles without bus_ack.
module rv32i_lsu
    import be_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic             clk,
    input  logic             rst,
    rv32i_lsu_if.slave       lsu
);
    localparam int BE_W  = XLEN / 8;
    localparam int OFF_W = $clog2(BE_W);

    lsu_state_t        state, state_nxt;
    lsu_op_t           op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   wdata_q, rdata_q;
    logic              err_q;

    logic              accept, bad_req, store_q, acked, timed_out;
    logic [XLEN-1:0]   al_wrdata, al_rdata;
    logic [BE_W-1:0]   al_be;

    assign accept  = lsu.req_valid && (state == IDLE);
    assign bad_req = op_misaligned(lsu.req_op, 3'(lsu.req_addr[OFF_W-1:0]), XLEN == 64);
    assign store_q = op_is_store(op_q);
    assign acked   = (state == ACCESS) && lsu.bus_ack;

`ifdef RV32I_LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] to_cnt;

    // Count un-acked ACCESS cycles; cleared whenever we are outside ACCESS
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                  to_cnt <= '0;
        else if (state != ACCESS)  to_cnt <= '0;
        else if (!lsu.bus_ack)     to_cnt <= to_cnt + 1'b1;
    end

    assign timed_out = (state == ACCESS) && !lsu.bus_ack &&
                       (to_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign timed_out = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state: misaligned requests skip the bus entirely
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = bad_req ? RESP : ACCESS;
            ACCESS:  if (lsu.bus_ack || timed_out) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture on accept, load data capture on ack, error on timeout
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q    <= LB;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            op_q    <= lsu.req_op;
            addr_q  <= lsu.req_addr;
            wdata_q <= lsu.req_wdata;
            rdata_q <= '0;
            err_q   <= bad_req;
        end else if (acked) begin
            rdata_q <= store_q ? '0 : al_rdata;
        end else if (timed_out) begin
            err_q   <= 1'b1;
        end
    end

    rv32i_lsu_align #(.XLEN(XLEN)) u_align (
        .op     (op_q),
        .off    (addr_q[OFF_W-1:0]),
        .wdata  (wdata_q),
        .rddata (lsu.bus_rddata),
        .wrdata (al_wrdata),
        .be     (al_be),
        .rdata  (al_rdata)
    );

    // Outputs decoded from state only, so an async reset zeroes them at once
    always_comb begin
        lsu.req_ready  = (state == IDLE);
        lsu.resp_valid = 1'b0;
        lsu.resp_err   = 1'b0;
        lsu.resp_rdata = '0;
        lsu.bus_addr   = '0;
        lsu.bus_wrdata = '0;
        lsu.bus_be     = '0;
        lsu.bus_wren   = 1'b0;
        lsu.bus_rden   = 1'b0;
        case (state)
            ACCESS: begin
                lsu.bus_addr   = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                lsu.bus_wrdata = al_wrdata;
                lsu.bus_be     = al_be;
                lsu.bus_wren   = store_q;
                lsu.bus_rden   = !store_q;
            end
            RESP: begin
                lsu.resp_valid = 1'b1;
                lsu.resp_err   = err_q;
                lsu.resp_rdata = err_q ? '0 : rdata_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rv32i_lsu.sv
// Directed bench for rv32i_lsu: vector table plus hand-written sequences
// for delayed ack, reset mid-access and the optional timeout.
module tb_rv32i_lsu;
    import be_pkg::*;

    localparam int XLEN = 32;
    localparam int ADDR_W = 32;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rv32i_lsu_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus_if ();

    rv32i_lsu #(.XLEN(XLEN), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TO)) dut (
        .clk (clk),
        .rst (rst),
        .lsu (bus_if)
    );

    typedef struct {
        lsu_op_t     op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rddata;
        logic        err;
        logic [31:0] baddr;
        logic [3:0]  be;
        logic [31:0] wrdata;
        logic [31:0] rdata;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_req(input lsu_op_t op, input logic [31:0] addr, input logic [31:0] wdata);
        bus_if.req_valid = 1'b1;
        bus_if.req_op    = op;
        bus_if.req_addr  = addr;
        bus_if.req_wdata = wdata;
    endtask

    initial begin
        bus_if.req_valid  = 1'b0;
        bus_if.req_op     = LB;
        bus_if.req_addr   = '0;
        bus_if.req_wdata  = '0;
        bus_if.bus_ack    = 1'b0;
        bus_if.bus_rddata = '0;

        vecs[0]  = '{SW,  32'h100, 32'hDEADBEEF, 32'h0,        1'b0, 32'h100, 4'hF, 32'hDEADBEEF, 32'h0};
        vecs[1]  = '{LB,  32'h103, 32'h0,        32'h80FF0000, 1'b0, 32'h100, 4'h8, 32'h0,        32'hFFFFFF80};
        vecs[2]  = '{LBU, 32'h103, 32'h0,        32'h80FF0000, 1'b0, 32'h100, 4'h8, 32'h0,        32'h00000080};
        vecs[3]  = '{SH,  32'h202, 32'h1234ABCD, 32'h0,        1'b0, 32'h200, 4'hC, 32'hABCDABCD, 32'h0};
        vecs[4]  = '{LW,  32'h101, 32'h0,        32'hFFFFFFFF, 1'b1, 32'h0,   4'h0, 32'h0,        32'h0};
        vecs[5]  = '{LH,  32'h006, 32'h0,        32'h80017FFF, 1'b0, 32'h004, 4'hC, 32'h0,        32'hFFFF8001};
        vecs[6]  = '{LHU, 32'h002, 32'h0,        32'h80010000, 1'b0, 32'h000, 4'hC, 32'h0,        32'h00008001};
        vecs[7]  = '{SB,  32'h011, 32'h000000A5, 32'h0,        1'b0, 32'h010, 4'h2, 32'hA5A5A5A5, 32'h0};
        vecs[8]  = '{LW,  32'h1F0, 32'h0,        32'hCAFEF00D, 1'b0, 32'h1F0, 4'hF, 32'h0,        32'hCAFEF00D};
        vecs[9]  = '{SH,  32'h101, 32'h5555AAAA, 32'h0,        1'b1, 32'h0,   4'h0, 32'h0,        32'h0};
        vecs[10] = '{LH,  32'h100, 32'h0,        32'h12347FFF, 1'b0, 32'h100, 4'h3, 32'h0,        32'h00007FFF};
        vecs[11] = '{SW,  32'h102, 32'h01020304, 32'h0,        1'b1, 32'h0,   4'h0, 32'h0,        32'h0};
        vecs[12] = '{LB,  32'h100, 32'h0,        32'h0000007F, 1'b0, 32'h100, 4'h1, 32'h0,        32'h0000007F};

        // Reset state while rst is held low
        #12;
        chk("rst.req_ready",  bus_if.req_ready, 1);
        chk("rst.resp_valid", bus_if.resp_valid, 0);
        chk("rst.resp_err",   bus_if.resp_err, 0);
        chk("rst.resp_rdata", bus_if.resp_rdata, 0);
        chk("rst.strobes",    {bus_if.bus_wren, bus_if.bus_rden}, 0);
        chk("rst.bus_be",     bus_if.bus_be, 0);
        chk("rst.bus_addr",   bus_if.bus_addr, 0);
        chk("rst.bus_wrdata", bus_if.bus_wrdata, 0);
        @(negedge clk);
        rst = 1'b1;

        // Table-driven transactions, ack in the first ACCESS cycle
        for (int i = 0; i < NV; i++) begin
            logic st;
            st = vecs[i].op inside {SB, SH, SW};
            @(negedge clk);
            drive_req(vecs[i].op, vecs[i].addr, vecs[i].wdata);
            @(negedge clk);
            bus_if.req_valid = 1'b0;
            if (vecs[i].err) begin
                chk($sformatf("v%0d.resp_valid", i), bus_if.resp_valid, 1);
                chk($sformatf("v%0d.resp_err", i),   bus_if.resp_err, 1);
                chk($sformatf("v%0d.resp_rdata", i), bus_if.resp_rdata, 0);
                chk($sformatf("v%0d.strobes", i),    {bus_if.bus_wren, bus_if.bus_rden}, 0);
                chk($sformatf("v%0d.bus_be", i),     bus_if.bus_be, 0);
            end else begin
                chk($sformatf("v%0d.early_resp", i), bus_if.resp_valid, 0);
                chk($sformatf("v%0d.bus_addr", i),   bus_if.bus_addr, vecs[i].baddr);
                chk($sformatf("v%0d.bus_be", i),     bus_if.bus_be, vecs[i].be);
                chk($sformatf("v%0d.wren", i),       bus_if.bus_wren, st);
                chk($sformatf("v%0d.rden", i),       bus_if.bus_rden, !st);
                if (st) chk($sformatf("v%0d.wrdata", i), bus_if.bus_wrdata, vecs[i].wrdata);
                bus_if.bus_ack    = 1'b1;
                bus_if.bus_rddata = vecs[i].rddata;
                @(negedge clk);
                bus_if.bus_ack = 1'b0;
                chk($sformatf("v%0d.resp_valid", i), bus_if.resp_valid, 1);
                chk($sformatf("v%0d.resp_err", i),   bus_if.resp_err, 0);
                chk($sformatf("v%0d.resp_rdata", i), bus_if.resp_rdata, vecs[i].rdata);
                chk($sformatf("v%0d.strobes_off", i), {bus_if.bus_wren, bus_if.bus_rden, bus_if.bus_be}, 0);
            end
            @(negedge clk);
            chk($sformatf("v%0d.pulse_end", i), bus_if.resp_valid, 0);
            chk($sformatf("v%0d.ready", i),     bus_if.req_ready, 1);
        end

        // bus_ack while idle must be ignored
        @(negedge clk);
        bus_if.bus_ack = 1'b1;
        @(negedge clk);
        bus_if.bus_ack = 1'b0;
        chk("idle_ack.ready", bus_if.req_ready, 1);
        chk("idle_ack.resp",  bus_if.resp_valid, 0);

        // Delayed ack: bus outputs stay constant across ACCESS
        @(negedge clk);
        drive_req(LW, 32'h40, 32'h0);
        @(negedge clk);
        bus_if.req_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("dly%0d.rden", k), bus_if.bus_rden, 1);
            chk($sformatf("dly%0d.addr", k), bus_if.bus_addr, 32'h40);
            chk($sformatf("dly%0d.be", k),   bus_if.bus_be, 4'hF);
            chk($sformatf("dly%0d.resp", k), bus_if.resp_valid, 0);
            @(negedge clk);
        end
        bus_if.bus_ack    = 1'b1;
        bus_if.bus_rddata = 32'h11223344;
        @(negedge clk);
        bus_if.bus_ack = 1'b0;
        chk("dly.resp_valid", bus_if.resp_valid, 1);
        chk("dly.resp_rdata", bus_if.resp_rdata, 32'h11223344);
        @(negedge clk);

`ifdef RV32I_LSU_TIMEOUT_EN
        begin
            int n;
            logic seen;
            n = 0;
            seen = 1'b0;
            drive_req(LW, 32'h10, 32'h0);
            @(negedge clk);
            bus_if.req_valid = 1'b0;
            for (int k = 0; k < 40 && !seen; k++) begin
                if (bus_if.resp_valid) seen = 1'b1;
                else begin
                    if (bus_if.bus_rden) n++;
                    @(negedge clk);
                end
            end
            chk("to.seen",   seen, 1);
            chk("to.cycles", n, TO);
            chk("to.err",    bus_if.resp_err, 1);
            chk("to.rdata",  bus_if.resp_rdata, 0);
            chk("to.rden",   bus_if.bus_rden, 0);
            @(negedge clk);
        end
`else
        begin
            logic seen;
            seen = 1'b0;
            drive_req(LW, 32'h10, 32'h0);
            @(negedge clk);
            bus_if.req_valid = 1'b0;
            for (int k = 0; k < 100; k++) begin
                if (bus_if.resp_valid) seen = 1'b1;
                @(negedge clk);
            end
            chk("noto.seen", seen, 0);
            chk("noto.rden", bus_if.bus_rden, 1);
            bus_if.bus_ack    = 1'b1;
            bus_if.bus_rddata = 32'h0BADF00D;
            @(negedge clk);
            bus_if.bus_ack = 1'b0;
            chk("noto.resp_valid", bus_if.resp_valid, 1);
            chk("noto.resp_rdata", bus_if.resp_rdata, 32'h0BADF00D);
            @(negedge clk);
        end
`endif

        // Reset pulse during ACCESS drops the request; next request works
        @(negedge clk);
        drive_req(SW, 32'h80, 32'h11111111);
        @(negedge clk);
        bus_if.req_valid = 1'b0;
        chk("mid.wren_before", bus_if.bus_wren, 1);
        #2 rst = 1'b0;
        #1;
        chk("mid.wren",   bus_if.bus_wren, 0);
        chk("mid.be",     bus_if.bus_be, 0);
        chk("mid.addr",   bus_if.bus_addr, 0);
        chk("mid.wrdata", bus_if.bus_wrdata, 0);
        chk("mid.ready",  bus_if.req_ready, 1);
        chk("mid.resp",   bus_if.resp_valid, 0);
        @(negedge clk);
        chk("mid.resp_held", bus_if.resp_valid, 0);
        rst = 1'b1;
        drive_req(LW, 32'h84, 32'h0);
        @(negedge clk);
        bus_if.req_valid = 1'b0;
        chk("post.resp_none", bus_if.resp_valid, 0);
        chk("post.rden",      bus_if.bus_rden, 1);
        chk("post.addr",      bus_if.bus_addr, 32'h84);
        bus_if.bus_ack    = 1'b1;
        bus_if.bus_rddata = 32'hA5A55A5A;
        @(negedge clk);
        bus_if.bus_ack = 1'b0;
        chk("post.resp_valid", bus_if.resp_valid, 1);
        chk("post.resp_err",   bus_if.resp_err, 0);
        chk("post.resp_rdata", bus_if.resp_rdata, 32'hA5A55A5A);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv32i_lsu.md
RV32I_LSU -- requirements
Module: rv32i_lsu

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits; legal values are 32 and 64.
REQ-002 SHALL have parameter ADDR_W, default 32, address width in bits.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 16, maximum ACCESS cycles before error.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have req_valid input 1, request present; req_ready output 1, LSU can accept.
REQ-007 SHALL have req_op input lsu_op_t, one of LB LH LW LBU LHU SB SH SW (LD/LWU/SD when XLEN=64).
REQ-008 SHALL have req_addr input ADDR_W and req_wdata input XLEN: byte address, store source.
REQ-009 SHALL have resp_valid output 1, resp_rdata output XLEN, resp_err output 1: response pulse, load result, error flag.
REQ-010 SHALL have bus_addr output ADDR_W, word-aligned (low log2(XLEN/8) bits zero).
REQ-011 SHALL have bus_wrdata output XLEN and bus_be output XLEN/8: lane-steered data, byte enables.
REQ-012 SHALL have bus_wren and bus_rden output 1 (strobes); bus_ack input 1 (completion); bus_rddata input XLEN (read data).

Function
REQ-013 SHALL implement FSM states IDLE, ACCESS, RESP; req_ready=1 only in IDLE.
REQ-014 SHALL accept a request on a clk edge where req_valid && req_ready, registering op, addr, wdata.
REQ-015 SHALL move IDLE->ACCESS on an aligned accept; misaligned accept (H not 2-aligned, W not 4-aligned, D not 8-aligned) SHALL go IDLE->RESP with resp_err=1 and no bus strobe.
REQ-016 SHALL hold bus_rden (loads) or bus_wren (stores) plus bus_addr/bus_be/bus_wrdata constant throughout ACCESS.
REQ-017 SHALL move ACCESS->RESP on the edge where bus_ack=1, capturing bus_rddata.
REQ-018 SHALL assert resp_valid for exactly one cycle in RESP, then return to IDLE; there is no response backpressure.
REQ-019 SHALL give minimum latency of 2 cycles accept-to-resp_valid when bus_ack=1 in the first ACCESS cycle.
REQ-020 SHALL replicate store data across lanes: SB byte into every byte lane, SH half into every half lane; bus_be = lane mask shifted by addr low bits.
REQ-021 SHALL extract the load lane by addr low bits; LB/LH/LW SHALL sign-extend to XLEN, LBU/LHU/LWU SHALL zero-extend.
REQ-022 SHALL drive resp_rdata=0 for stores and errored responses.
REQ-023 SHALL ignore bus_ack outside ACCESS.
REQ-024 SHALL drive all bus strobes and bus_be to 0 outside ACCESS.

Reset
REQ-025 SHALL, on rst=0 at any time including mid-ACCESS, immediately go to IDLE with req_ready=1 and resp_valid, resp_err, bus_wren, bus_rden, bus_be, bus_addr, bus_wrdata, resp_rdata = 0; the in-flight request SHALL be dropped with no response.
REQ-026 SHALL accept its first request on the first clk edge after rst deasserts.

Configuration
REQ-027 SHALL, when RV32I_LSU_TIMEOUT_EN is defined, count ACCESS cycles; if TIMEOUT_CYC cycles elapse without bus_ack, it SHALL deassert strobes, go to RESP with resp_err=1, and reset the counter on each ACCESS entry.
REQ-028 SHALL, when RV32I_LSU_TIMEOUT_EN is undefined, wait in ACCESS indefinitely with no counter logic present.

Structure
REQ-029 SHALL take lsu_op_t and lsu_state_t from be_pkg.
REQ-030 SHALL place lane steering and extension in the combinational sub-module rv32i_lsu_align.

Verification
REQ-031 SW addr 0x100 wdata 0xDEADBEEF, ack in first ACCESS cycle -> bus_be=0xF, bus_wrdata=0xDEADBEEF, resp_valid 2 cycles after accept, resp_err=0.
REQ-032 LB addr 0x103, bus_rddata 0x80FF0000 -> resp_rdata 0xFFFFFF80; LBU same -> 0x00000080.
REQ-033 SH addr 0x202 wdata 0x1234ABCD -> bus_addr 0x200, bus_be=0xC, bus_wrdata 0xABCDABCD.
REQ-034 LW addr 0x101 -> no strobe ever, resp_valid 1 cycle after accept, resp_err=1, resp_rdata=0.
REQ-035 With RV32I_LSU_TIMEOUT_EN, TIMEOUT_CYC=16, LW with bus_ack held 0 -> resp_err=1 after 16 ACCESS cycles; without the macro -> still in ACCESS after 100 cycles.
REQ-036 rst=0 pulse during ACCESS -> outputs 0 the same cycle, no resp_valid; a new request after reset completes normally.
